uart_rx_ctrl: RTL and testbench

//  Sequences the UART receive path: gates uart_rx via rx_enable_o, buffers received bytes in a FWFT FIFO,
//  and raises sticky interrupts: watermark (level), overflow, frame, parity, timeout, break.

---
 rtl/uart_rx_ctrl.sv | 124 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: rx enable FSM, FWFT byte FIFO, sticky rx interrupts.
// Pushed byte visible on rd_data_o the next cycle; a push into a full FIFO with no same-cycle pop is dropped and flagged.
module uart_rx_ctrl #(
  parameter int DEPTH       = 16,
  parameter int TO_W        = 8,
  parameter int BREAK_TICKS = 22,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = $clog2(BREAK_TICKS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_enable_i,
  input  logic [TO_W-1:0] cfg_timeout_i,
  input  logic [AW:0]     cfg_watermark_i,
  input  logic            rx_i,
  input  logic            tick_baud_i,
  input  logic            rx_idle_i,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  input  logic            frame_err_i,
  input  logic            parity_err_i,
  output logic            rx_enable_o,
  input  logic            fifo_clr_i,
  output logic            rd_valid_o,
  output logic [7:0]      rd_data_o,
  input  logic            rd_ready_i,
  output logic [AW:0]     fifo_level_o,
  input  logic [5:0]      intr_clr_i,
  output logic [5:0]      intr_o
);

  localparam logic [1:0] ST_OFF      = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;
  localparam logic [1:0] ST_BREAK    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic [BW-1:0]   brk_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [5:1]      flags_q;
  logic [5:1]      flags_set;
  logic            rx_on, empty, full, pop, push_req, push, ovf_set;
  logic            brk_last, brk_det, to_zero, to_inc, to_set, wm;
  logic            unused_clr;

  // Bit 0 of the clear vector maps onto the non-sticky watermark.
  assign unused_clr = intr_clr_i[0];

  assign rx_on    = (state_q == ST_ACTIVE) || (state_q == ST_STOPPING);
  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign pop      = !empty && rd_ready_i;
  assign push_req = rx_valid_i && rx_on;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop && !fifo_clr_i;

  assign brk_last = (brk_cnt_q == BW'(BREAK_TICKS - 1));
  assign brk_det  = (state_q == ST_ACTIVE) && tick_baud_i && !rx_i && brk_last;

  assign to_zero  = push || pop || fifo_clr_i || empty;
  assign to_inc   = !to_zero && tick_baud_i && (to_cnt_q != '1);
  assign to_set   = to_inc && (cfg_timeout_i != '0) && ((to_cnt_q + TO_W'(1)) == cfg_timeout_i);

  assign flags_set = {brk_det, to_set, push_req && parity_err_i, push_req && frame_err_i, ovf_set};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:      if (cfg_enable_i) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (brk_det)            state_d = ST_BREAK;
        else if (!cfg_enable_i) state_d = ST_STOPPING;
      end
      ST_STOPPING: if (rx_idle_i) state_d = ST_OFF;
      ST_BREAK:    if (rx_i && rx_idle_i) state_d = ST_ACTIVE;
      default:     state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      brk_cnt_q <= '0;
      to_cnt_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      level_q <= level_q + (AW+1)'(1);
        else if (pop && !push) level_q <= level_q - (AW+1)'(1);
      end
      // Saturating at the threshold keeps a long low line re-detectable on ACTIVE entry.
      if (rx_i)                          brk_cnt_q <= '0;
      else if (tick_baud_i && !brk_last) brk_cnt_q <= brk_cnt_q + BW'(1);
      if (to_zero)     to_cnt_q <= '0;
      else if (to_inc) to_cnt_q <= to_cnt_q + TO_W'(1);
      flags_q <= (flags_q & ~intr_clr_i[5:1]) | flags_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !fifo_clr_i) mem[wr_ptr_q] <= rx_data_i;
  end

  assign wm           = (cfg_watermark_i != '0) && (level_q >= cfg_watermark_i);
  assign rx_enable_o  = (state_q != ST_OFF);
  assign rd_valid_o   = !empty;
  assign rd_data_o    = empty ? 8'h00 : mem[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign intr_o       = {flags_q, wm};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; popped bytes are checked against a scoreboard queue by a negedge monitor.
module tb_uart_rx_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_enable_i;
  logic [7:0] cfg_timeout_i;
  logic [4:0] cfg_watermark_i;
  logic       rx_i, tick_baud_i, rx_idle_i, rx_valid_i;
  logic [7:0] rx_data_i;
  logic       frame_err_i, parity_err_i;
  logic       rx_enable_o;
  logic       fifo_clr_i;
  logic       rd_valid_o;
  logic [7:0] rd_data_o;
  logic       rd_ready_i;
  logic [4:0] fifo_level_o;
  logic [5:0] intr_clr_i;
  logic [5:0] intr_o;

  int npass = 0;
  int ntotal = 0;
  logic [7:0] sb [$];

  always #5 clk_i = ~clk_i;

  uart_rx_ctrl #(.DEPTH(16), .TO_W(8), .BREAK_TICKS(22)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i), .cfg_timeout_i(cfg_timeout_i),
    .cfg_watermark_i(cfg_watermark_i), .rx_i(rx_i), .tick_baud_i(tick_baud_i), .rx_idle_i(rx_idle_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .frame_err_i(frame_err_i),
    .parity_err_i(parity_err_i), .rx_enable_o(rx_enable_o), .fifo_clr_i(fifo_clr_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .fifo_level_o(fifo_level_o), .intr_clr_i(intr_clr_i), .intr_o(intr_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk_i) begin
    if (!rst_i && rd_valid_o && rd_ready_i) begin
      if (sb.size() == 0) check("pop_unexpected", {24'h0, rd_data_o}, 32'hFFFF_FFFF);
      else check("pop_data", {24'h0, rd_data_o}, {24'h0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit exp);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    if (exp) sb.push_back(b);
    step();
    rx_valid_i = 1'b0;
  endtask

  task automatic pop();
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_baud_i = 1'b1;
      step();
    end
    tick_baud_i = 1'b0;
  endtask

  task automatic clr_intr(input logic [5:0] m);
    intr_clr_i = m;
    step();
    intr_clr_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; cfg_enable_i = 1'b0; cfg_timeout_i = '0; cfg_watermark_i = '0;
    rx_i = 1'b1; tick_baud_i = 1'b0; rx_idle_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0;
    frame_err_i = 1'b0; parity_err_i = 1'b0; fifo_clr_i = 1'b0; rd_ready_i = 1'b0; intr_clr_i = '0;
    step(); step();
    rst_i = 1'b0;
    check("rst_rx_enable", rx_enable_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_intr", intr_o, 0);

    // Basic push/pop
    cfg_enable_i = 1'b1;
    step();
    check("en_rx_enable", rx_enable_o, 1);
    push(8'h55, 1'b1);
    check("t1_level1", fifo_level_o, 1);
    check("t1_valid", rd_valid_o, 1);
    push(8'hA3, 1'b1);
    check("t1_level2", fifo_level_o, 2);
    pop();
    check("t1_level3", fifo_level_o, 1);
    pop();
    check("t1_level4", fifo_level_o, 0);
    check("t1_intr", intr_o, 0);

    // Fill past full, then push+pop while full
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    push(8'h99, 1'b0);
    check("t2_level_full", fifo_level_o, 16);
    check("t2_overflow", intr_o, 6'b000010);
    rx_data_i = 8'h77; rx_valid_i = 1'b1; rd_ready_i = 1'b1;
    sb.push_back(8'h77);
    step();
    rx_valid_i = 1'b0; rd_ready_i = 1'b0;
    check("t2_level_pushpop", fifo_level_o, 16);
    clr_intr(6'b000010);
    check("t2_ovf_cleared", intr_o, 0);
    for (int i = 0; i < 16; i++) pop();
    check("t2_drained", fifo_level_o, 0);
    check("t2_sb_empty", sb.size(), 0);

    // Watermark, set-beats-clear, flush
    cfg_watermark_i = 5'd4;
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i), 1'b1);
    check("t3_wm_below", intr_o[0], 0);
    push(8'h23, 1'b1);
    check("t3_wm_at", intr_o[0], 1);
    pop();
    check("t3_wm_after_pop", intr_o[0], 0);
    for (int i = 0; i < 13; i++) push(8'h30 + 8'(i), 1'b1);
    check("t3_full", fifo_level_o, 16);
    rx_data_i = 8'hF0; rx_valid_i = 1'b1; intr_clr_i = 6'b000010;
    step();
    rx_valid_i = 1'b0; intr_clr_i = '0;
    check("t3_set_beats_clr", intr_o[1], 1);
    clr_intr(6'b000010);
    check("t3_ovf_clr_wm", intr_o, 6'b000001);
    rx_data_i = 8'hF1; rx_valid_i = 1'b1; fifo_clr_i = 1'b1;
    step();
    rx_valid_i = 1'b0; fifo_clr_i = 1'b0;
    sb.delete();
    check("t3_flush_level", fifo_level_o, 0);
    check("t3_flush_valid", rd_valid_o, 0);
    check("t3_flush_intr", intr_o, 0);
    cfg_watermark_i = '0;

    // Break detection
    push(8'h3C, 1'b1);
    rx_i = 1'b0;
    ticks(21);
    check("t4_no_break_21", intr_o[5], 0);
    ticks(1);
    check("t4_break", intr_o[5], 1);
    check("t4_break_rx_en", rx_enable_o, 1);
    frame_err_i = 1'b1;
    push(8'hEE, 1'b0);
    frame_err_i = 1'b0;
    check("t4_break_level", fifo_level_o, 1);
    check("t4_break_noframe", intr_o[2], 0);
    rx_i = 1'b1;
    step();
    push(8'h42, 1'b1);
    check("t4_active_again", fifo_level_o, 2);
    pop(); pop();
    clr_intr(6'b100000);
    check("t4_clean", intr_o, 0);

    // Timeout
    cfg_timeout_i = 8'd3;
    push(8'h11, 1'b1);
    ticks(2);
    check("t5_no_to_2", intr_o[4], 0);
    ticks(1);
    check("t5_to_3", intr_o[4], 1);
    clr_intr(6'b010000);
    pop();
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    ticks(2);
    pop();
    ticks(2);
    check("t5_pop_resets", intr_o[4], 0);
    pop();
    ticks(4);
    check("t5_empty_no_to", intr_o[4], 0);
    cfg_timeout_i = '0;

    // Frame/parity flags, graceful stop, reset
    frame_err_i = 1'b1;
    push(8'h5A, 1'b1);
    frame_err_i = 1'b0;
    check("t6_frame", intr_o, 6'b000100);
    parity_err_i = 1'b1;
    push(8'h5B, 1'b1);
    parity_err_i = 1'b0;
    check("t6_parity", intr_o, 6'b001100);
    rx_idle_i = 1'b0; cfg_enable_i = 1'b0;
    step(); step();
    check("t6_stopping", rx_enable_o, 1);
    rx_idle_i = 1'b1;
    step();
    check("t6_off", rx_enable_o, 0);
    check("t6_off_keeps", fifo_level_o, 2);
    cfg_enable_i = 1'b1;
    step();
    rst_i = 1'b1;
    step();
    sb.delete();
    check("t6_rst_intr", intr_o, 0);
    check("t6_rst_level", fifo_level_o, 0);
    check("t6_rst_valid", rd_valid_o, 0);
    check("t6_rst_data", rd_data_o, 0);
    check("t6_rst_rx_en", rx_enable_o, 0);
    rst_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
